// File: rtl/booth_mult.sv
`default_nettype none
// ============================================================================
// Module   : booth_mult
// Purpose  : Radix-2 Booth sequential signed multiplier, WIDTH steps per product.
//            Optional macro BOOTH_MULT_ZERO_SKIP_EN: zero operands finish in 1 cycle.
// Revision : 1.0 - initial release
// ============================================================================
module booth_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mult_in,
    output logic             mult_out,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [1:0]       S_IDLE    = 2'd0;
    localparam logic [1:0]       S_RUN     = 2'd1;
    localparam logic [1:0]       S_DONE    = 2'd2;
    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic             qm1_q,   qm1_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic [WIDTH-1:0] lo_q,    lo_d;
    logic             done_q,  done_d;

    logic             zero_start;
    logic             last_step;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] shift_acc;
    logic [WIDTH-1:0] shift_q;

    always_comb begin
`ifdef BOOTH_MULT_ZERO_SKIP_EN
        zero_start = (A == '0) || (B == '0);
`else
        zero_start = 1'b0;
`endif
    end

    assign last_step = (cnt_q == LAST_STEP);

    // State register and all datapath flops
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mult_in) begin
                    state_d = zero_start ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One Booth step; the extra sign bit keeps -2^(WIDTH-1) exact through add/sub
    always_comb begin
        case ({q_q[0], qm1_q})
            2'b01:   sum = {acc_q[WIDTH-1], acc_q} + {mcand_q[WIDTH-1], mcand_q};
            2'b10:   sum = {acc_q[WIDTH-1], acc_q} - {mcand_q[WIDTH-1], mcand_q};
            default: sum = {acc_q[WIDTH-1], acc_q};
        endcase
        shift_acc = sum[WIDTH:1];
        shift_q   = {sum[0], q_q[WIDTH-1:1]};
    end

    // Datapath register updates
    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mult_in) begin
                    mcand_d = A;
                    q_d     = B;
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    if (zero_start) begin
                        hi_d   = '0;
                        lo_d   = '0;
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                acc_d = shift_acc;
                q_d   = shift_q;
                qm1_d = q_q[0];
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    hi_d   = shift_acc;
                    lo_d   = shift_q;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        busy     = (state_q != S_IDLE);
        mult_out = done_q;
        HI       = hi_q;
        LO       = lo_q;
    end

endmodule
`default_nettype wire

// File: doc/booth_mult.md
BOOTH_MULT -- requirements
Module: booth_mult

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; HI and LO are each WIDTH bits; the CPU instantiates only WIDTH=32.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 A  input  WIDTH  multiplicand, two's complement, sampled only at the start edge.
REQ-005 B  input  WIDTH  multiplier, two's complement, sampled only at the start edge.
REQ-006 mult_in  input  1  start request; acted on only in IDLE.
REQ-007 mult_out  output  1  done strobe, registered, high for exactly one cycle per completed operation.
REQ-008 busy  output  1  high in RUN and DONE.
REQ-009 HI  output  WIDTH  upper half of the signed 2*WIDTH-bit product.
REQ-010 LO  output  WIDTH  lower half of the signed 2*WIDTH-bit product.

Function
REQ-011 The block SHALL be a radix-2 Booth sequential multiplier with states IDLE, RUN and DONE.
REQ-012 In IDLE, the first rising edge with mult_in=1 (the start edge) SHALL:
- latch A and B;
- clear the accumulator, Booth bit Q-1 and the step counter;
- enter RUN.
REQ-013 Each RUN edge SHALL perform one Booth step:
- examine {Q0,Q-1};
- 01: add the multiplicand to the upper accumulator; 10: subtract it; 00/11: no operation;
- then arithmetic-shift {acc,Q,Q-1} right by 1;
- the add/subtract SHALL use WIDTH+1-bit internal precision so that multiplicand = -2^(WIDTH-1) is handled correctly.
REQ-014 After the WIDTH-th step (edge start+WIDTH), the FSM SHALL enter DONE, and on that same edge HI/LO SHALL load the product and mult_out SHALL rise.
REQ-015 Latency: mult_out SHALL be high during the cycle following edge start+WIDTH (start+32 for WIDTH=32).
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE with mult_out=0.
REQ-017 HI/LO SHALL change only at completion and SHALL hold their value until the next completion or reset.
REQ-018 mult_in SHALL be ignored while busy=1, including the DONE cycle; a new operation may be accepted on the first IDLE edge after DONE.
REQ-019 A and B changing during RUN SHALL NOT affect the result.
REQ-020 The result SHALL equal the exact signed product for all operand pairs, including -2^31 * -2^31.

Reset
REQ-021 reset=1 SHALL immediately force state IDLE, HI=0, LO=0, mult_out=0, busy=0, and clear the accumulator and counter, regardless of the current state.
REQ-022 A reset asserted mid-RUN SHALL abort the operation with no mult_out pulse; HI/LO SHALL read 0.
REQ-023 After reset deasserts, the first edge with mult_in=1 SHALL start a fresh operation.

Configuration
REQ-024 With macro BOOTH_MULT_ZERO_SKIP_EN defined:
- a start edge with A==0 or B==0 SHALL go directly to DONE;
- HI=0, LO=0 and mult_out SHALL be high in the cycle after the start edge (latency 1).
REQ-025 Without BOOTH_MULT_ZERO_SKIP_EN, zero operands SHALL take the full WIDTH-step latency, like any other operand pair.

Verification
REQ-026 A=3, B=5, pulse mult_in -> mult_out high exactly 32 cycles after the start edge; HI=0x00000000, LO=0x0000000F; busy high for 33 cycles.
REQ-027 A=-7 (0xFFFFFFF9), B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-028 A=B=0x80000000 -> HI=0x40000000, LO=0x00000000; then A=B=0xFFFFFFFF -> HI=0, LO=1.
REQ-029 Start with A=2, B=2; at cycle 10 drive mult_in=1 with A=9, B=9; change A/B during RUN -> single mult_out pulse, LO=4; the second request is ignored.
REQ-030 Start with A=100, B=100; assert reset at cycle 15 -> HI=LO=0, no mult_out pulse, busy=0; next start with A=6, B=7 -> LO=42 after 32 cycles.
REQ-031 A=0, B=0x1234: with BOOTH_MULT_ZERO_SKIP_EN, mult_out at latency 1 with HI=LO=0; without it, latency 32 with HI=LO=0.
